// File: rtl/ms_timer_scheduler_if.sv
// Request/response bundle between requesters and the ms timer scheduler.
// MS_TIMER_SCHED_PERIODIC_EN adds the per-channel periodic flag.
interface ms_timer_scheduler_if #(
  parameter int NCH = 4,
  parameter int DW  = 16
);
  logic [NCH-1:0]         req;
  logic [NCH-1:0][DW-1:0] req_delay;
  logic [NCH-1:0]         cancel;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
  logic [NCH-1:0]         req_periodic;
`endif
  logic [NCH-1:0]         gnt;
  logic [NCH-1:0]         busy;
  logic [NCH-1:0]         expire;

  modport master (
    output req, req_delay, cancel,
`ifdef MS_TIMER_SCHED_PERIODIC_EN
    output req_periodic,
`endif
    input  gnt, busy, expire
  );

  modport slave (
    input  req, req_delay, cancel,
`ifdef MS_TIMER_SCHED_PERIODIC_EN
    input  req_periodic,
`endif
    output gnt, busy, expire
  );
endinterface

// File: rtl/ms_timer_scheduler.sv
// Multi-channel 1 ms countdown timers behind a round-robin load arbiter.
// Optional MS_TIMER_SCHED_PERIODIC_EN makes channels auto-reload on expiry.
module ms_timer_chan #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          load,
  input  logic          cancel,
  input  logic [DW-1:0] delay,
`ifdef MS_TIMER_SCHED_PERIODIC_EN
  input  logic          periodic,
`endif
  output logic          busy,
  output logic          expire
);
  logic [DW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          exp_q, exp_d;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
  logic [DW-1:0] rel_q, rel_d;
  logic          per_q, per_d;
`endif

  // cancel beats load beats tick
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    exp_d  = 1'b0;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
    rel_d  = rel_q;
    per_d  = per_q;
`endif
    if (cancel) begin
      cnt_d  = '0;
      busy_d = 1'b0;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
      per_d  = 1'b0;
`endif
    end else if (load) begin
      cnt_d  = delay;
      busy_d = (delay != '0);
      exp_d  = (delay == '0);
`ifdef MS_TIMER_SCHED_PERIODIC_EN
      rel_d  = delay;
      per_d  = periodic && (delay != '0);
`endif
    end else if (busy_q && tick) begin
      if (cnt_q == DW'(1)) begin
        exp_d = 1'b1;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
        if (per_q) begin
          cnt_d = rel_q;
        end else begin
          cnt_d  = '0;
          busy_d = 1'b0;
        end
`else
        cnt_d  = '0;
        busy_d = 1'b0;
`endif
      end else begin
        cnt_d = cnt_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      exp_q  <= 1'b0;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
      rel_q  <= '0;
      per_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      exp_q  <= exp_d;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
      rel_q  <= rel_d;
      per_q  <= per_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign expire = exp_q;
endmodule

module ms_timer_scheduler #(
  parameter int NCH = 4,
  parameter int DW  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_1ms,
  ms_timer_scheduler_if.slave bus
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] busy_w, exp_w;

  // A channel granted last cycle sits out one cycle, so grants to it are >= 2 clks apart.
  always_comb begin
    int idx;
    elig  = bus.req & ~bus.cancel & ~gnt_q;
    gnt_d = '0;
    ptr_d = ptr_q;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (gnt_d == '0 && elig[PW'(idx)]) begin
        gnt_d[PW'(idx)] = 1'b1;
        ptr_d           = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= PW'(NCH - 1);
      gnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ms_timer_chan #(.DW(DW)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick_1ms),
      .load     (gnt_d[i]),
      .cancel   (bus.cancel[i]),
      .delay    (bus.req_delay[i]),
`ifdef MS_TIMER_SCHED_PERIODIC_EN
      .periodic (bus.req_periodic[i]),
`endif
      .busy     (busy_w[i]),
      .expire   (exp_w[i])
    );
  end

  assign bus.gnt    = gnt_q;
  assign bus.busy   = busy_w;
  assign bus.expire = exp_w;
endmodule

// File: doc/ms_timer_scheduler.md
Name: ms_timer_scheduler

Overview:
- Multi-channel millisecond timer service driven by the shared 1 ms tick from the board counter.
- Up to NCH requesters each arm a one-shot delay in ms.
- A round-robin arbiter admits one load per clock into the shared channel register file.
- Every armed channel decrements on each tick and raises a one-cycle expire pulse when it reaches zero.

Parameters:
- NCH, 4, number of requester channels (2..8)
- DW, 16, delay width in ms ticks

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick_1ms  input  1  one-clk-wide pulse per ms, synchronous to clk
- req  input  NCH  per-channel load request; held high until granted
- req_delay  input  NCH*DW  channel i delay in bits [i*DW +: DW]
- cancel  input  NCH  per-channel disarm, level-sampled each clk
- gnt  output  NCH  one-hot, one-cycle grant pulse (registered)
- busy  output  NCH  channel armed (registered)
- expire  output  NCH  one-cycle pulse when delay elapses (registered)

Behaviour:
- Reset (async, active-high): gnt=0, busy=0, expire=0, all counts=0, RR pointer=NCH-1, so channel 0 has highest priority first.
- Eligible set: req[i] & ~cancel[i] & ~gnt[i]. A channel whose gnt is currently high is never re-granted in the next cycle, so there are at least 2 clks between grants to the same channel.
- Arbitration: at each edge, grant the first eligible channel searching from pointer+1 upward, wrapping modulo NCH.
  - Pointer moves to the granted index.
  - No grant: pointer holds, gnt=0.
- Load: on the edge that asserts gnt[i], count[i] is set to req_delay[i] as sampled that cycle.
  - If delay ≥ 1: busy[i]=1 in the gnt cycle.
  - If delay = 0: busy stays 0 and expire[i] pulses in the gnt cycle.
  - Granting an already-busy channel restarts it with the new delay; no expire is issued for the old delay.
- Countdown: on an edge with tick_1ms=1, every busy channel not being loaded or cancelled at that edge decrements by 1.
  - 1→0 transition: busy[i] falls and expire[i] rises on the same edge; expire lasts exactly one cycle.
  - A delay of D therefore expires on the D-th tick strictly after the load edge.
- Simultaneous events on one channel, by precedence: cancel > load > tick decrement.
  - cancel[i]=1 clears busy[i] and count[i] at the next edge; no expire, no gnt.
  - A tick coinciding with the load edge is not counted.
- Multiple channels may expire on the same edge; expire bits are independent.
- Reset asserted mid-countdown: all channels disarm immediately and no expire is produced.
- The count never underflows: an idle channel with count 0 ignores ticks.

Optional Feature:
- Macro: MS_TIMER_SCHED_PERIODIC_EN
- Defined:
  - Adds input req_periodic [NCH], sampled with the grant, and a per-channel reload register of DW bits.
  - A periodic channel reloads count from its stored delay on the expire edge, stays busy, and pulses expire every D ticks until cancel or a re-grant.
  - A periodic load with delay 0 is treated as one-shot.
- Undefined: the port and reload registers are absent; all channels are one-shot.

Test Plan:
- Reset, then req[0]=1 with delay 3, ticks every 10 clks -> gnt[0] pulses 1 clk after req; busy[0]=1; expire[0] pulses on the 3rd tick edge after load; busy[0]=0 that same edge.
- req=4'b1111 held, delays all 2 -> gnt order 0,1,2,3 on consecutive clks; no channel is granted twice in a row; all busy.
- req[1] with delay 0 -> gnt[1] and expire[1] on the same cycle; busy[1] stays 0.
- Channel 2 armed with 5; after 2 ticks, re-grant with 4 -> no expire at the original 5th tick; expire at the 4th tick after the re-grant.
- Channel 3 armed with 2; cancel[3] asserted on the same clk as the 2nd tick -> no expire; busy[3]=0.
- With MS_TIMER_SCHED_PERIODIC_EN: channel 0 periodic, delay 2, over 7 ticks -> expire at ticks 2, 4, 6; then cancel -> no further expire.
